// File: rtl/commit_trace_buffer_pkg.sv
// Shared constants and FSM state encoding for the commit trace buffer.
package commit_trace_buffer_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DROP_W     = 16;
    localparam int unsigned TIME_W     = 32;
    localparam int unsigned STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        TRACE_IDLE  = 2'd0,
        TRACE_ARMED = 2'd1,
        TRACE_RUN   = 2'd2,
        TRACE_DONE  = 2'd3
    } trace_state_e;

endpackage

// File: rtl/commit_trace_fifo.sv
// First-word-fall-through FIFO with registered storage and wrap-bit pointers.
module trace_fifo #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Trigger-started capture of register writebacks into a drainable trace FIFO.
// Define TRACE_TIMESTAMP_EN to tag each entry with a free-running cycle count.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned DEPTH        = 16,
    parameter bit          STOP_ON_FULL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  prog_count,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg_addr,
    input  logic [WORD_SIZE-1:0]  write_reg_data,
    input  logic [WORD_SIZE-1:0]  trig_pc,
    input  logic                  arm,
    input  logic                  clear,
    input  logic                  trace_ready,
    output logic                  trace_valid,
    output logic [WORD_SIZE-1:0]  trace_pc,
    output logic [REG_ADDR_W-1:0] trace_addr,
    output logic [WORD_SIZE-1:0]  trace_data,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TIME_W-1:0]     trace_time,
`endif
    output logic [STATE_W-1:0]    state_out,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned LVL_W     = AW + 1;
    localparam int unsigned PAYLOAD_W = 2 * WORD_SIZE + REG_ADDR_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W   = PAYLOAD_W + TIME_W;
`else
    localparam int unsigned ENTRY_W   = PAYLOAD_W;
`endif

    trace_state_e       state_q;
    trace_state_e       state_d;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic               capture_event;
    logic               trigger_hit;
    logic               push_req;
    logic               pop_req;
    logic               push_ok;
    logic               drop_now;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;

    assign capture_event = reg_write && (write_reg_addr != '0);
    assign trigger_hit   = (state_q == TRACE_ARMED) && (prog_count == trig_pc);
    assign push_req      = capture_event && !clear && ((state_q == TRACE_RUN) || trigger_hit);
    assign pop_req       = !fifo_empty && trace_ready && !clear;
    assign push_ok       = push_req && (!fifo_full || pop_req);
    assign drop_now      = push_req && fifo_full && !pop_req;
    assign level_d       = level_q + LVL_W'(push_ok) - LVL_W'(pop_req);

    assign trace_valid = !fifo_empty;
    assign state_out   = STATE_W'(state_q);

`ifdef TRACE_TIMESTAMP_EN
    logic [TIME_W-1:0] cycle_q;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + TIME_W'(1);
        end
    end

    assign fifo_din = {cycle_q, prog_count, write_reg_addr, write_reg_data};
    assign {trace_time, trace_pc, trace_addr, trace_data} = fifo_dout;
`else
    assign fifo_din = {prog_count, write_reg_addr, write_reg_data};
    assign {trace_pc, trace_addr, trace_data} = fifo_dout;
`endif

    // Capture FSM: clear dominates, arm is only honoured from IDLE/DONE.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = TRACE_IDLE;
        end else begin
            case (state_q)
                TRACE_IDLE:  if (arm) state_d = TRACE_ARMED;
                TRACE_ARMED: if (trigger_hit) state_d = TRACE_RUN;
                TRACE_RUN:   if (STOP_ON_FULL && push_ok && (level_d == LVL_W'(DEPTH)))
                                 state_d = TRACE_DONE;
                TRACE_DONE:  if (arm) state_d = TRACE_ARMED;
                default:     state_d = TRACE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= TRACE_IDLE;
            level_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                level_q    <= '0;
                overflow   <= 1'b0;
                drop_count <= '0;
            end else begin
                level_q <= level_d;
                if (drop_now) begin
                    overflow <= 1'b1;
                    if (drop_count != '1) begin
                        drop_count <= drop_count + DROP_W'(1);
                    end
                end
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push_req),
        .din   (fifo_din),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: stop-on-full and drop-on-full instances against a queue model.
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] ts;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] prog_count;
    logic        reg_write;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_reg_data;
    logic [31:0] trig_pc;
    logic        arm;
    logic        clear;
    logic        trace_ready;

    logic        s_valid, d_valid;
    logic [31:0] s_pc, d_pc, s_data, d_data;
    logic [4:0]  s_addr, d_addr;
    logic [1:0]  s_state, d_state;
    logic        s_ovf, d_ovf;
    logic [15:0] s_drop, d_drop;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] s_time, d_time;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    ent_t        q0[$];
    ent_t        q1[$];
    int          m_state[2];
    bit          m_ovf[2];
    int          m_drops[2];
    logic [31:0] m_time;

    always #5 clk = ~clk;

    commit_trace_buffer #(.WORD_SIZE(32), .DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) dut_stop (
        .clk(clk), .rst(rst), .prog_count(prog_count), .reg_write(reg_write),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .trig_pc(trig_pc), .arm(arm), .clear(clear), .trace_ready(trace_ready),
        .trace_valid(s_valid), .trace_pc(s_pc), .trace_addr(s_addr), .trace_data(s_data),
`ifdef TRACE_TIMESTAMP_EN
        .trace_time(s_time),
`endif
        .state_out(s_state), .overflow(s_ovf), .drop_count(s_drop)
    );

    commit_trace_buffer #(.WORD_SIZE(32), .DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) dut_drop (
        .clk(clk), .rst(rst), .prog_count(prog_count), .reg_write(reg_write),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .trig_pc(trig_pc), .arm(arm), .clear(clear), .trace_ready(trace_ready),
        .trace_valid(d_valid), .trace_pc(d_pc), .trace_addr(d_addr), .trace_data(d_data),
`ifdef TRACE_TIMESTAMP_EN
        .trace_time(d_time),
`endif
        .state_out(d_state), .overflow(d_ovf), .drop_count(d_drop)
    );

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t qhead(input int idx);
        ent_t h;
        h = '0;
        if (idx == 0 && q0.size() > 0) h = q0[0];
        if (idx == 1 && q1.size() > 0) h = q1[0];
        return h;
    endfunction

    task automatic qpush(input int idx, input ent_t e);
        if (idx == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic qpop(input int idx);
        if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qclear(input int idx);
        if (idx == 0) q0.delete(); else q1.delete();
    endtask

    // Reference behaviour of one instance for the edge that just occurred.
    task automatic model_one(input int idx, input bit stop);
        bit   ev, trig, cap, pop, pushed;
        ent_t e;
        if (!rst || clear) begin
            qclear(idx);
            m_state[idx] = 0;
            m_ovf[idx]   = 1'b0;
            m_drops[idx] = 0;
            return;
        end
        ev   = reg_write && (write_reg_addr != 5'd0);
        pop  = (qsize(idx) > 0) && trace_ready;
        trig = (m_state[idx] == 1) && (prog_count == trig_pc);
        cap  = ev && ((m_state[idx] == 2) || trig);
        if (pop) qpop(idx);
        pushed = 1'b0;
        if (cap) begin
            if (qsize(idx) < DEPTH) begin
                e.pc   = prog_count;
                e.addr = write_reg_addr;
                e.data = write_reg_data;
                e.ts   = m_time;
                qpush(idx, e);
                pushed = 1'b1;
            end else begin
                m_ovf[idx] = 1'b1;
                if (m_drops[idx] < 65535) m_drops[idx]++;
            end
        end
        case (m_state[idx])
            0: if (arm) m_state[idx] = 1;
            1: if (trig) m_state[idx] = 2;
            2: if (stop && pushed && qsize(idx) == DEPTH) m_state[idx] = 3;
            default: if (arm) m_state[idx] = 1;
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int idx, input string n, input logic v, input logic [1:0] st,
                             input logic ov, input logic [15:0] dc, input logic [31:0] pc,
                             input logic [4:0] a, input logic [31:0] d);
        ent_t h;
        h = qhead(idx);
        chk({n, "_valid"}, 64'(v), 64'(qsize(idx) > 0));
        chk({n, "_state"}, 64'(st), 64'(m_state[idx]));
        chk({n, "_overflow"}, 64'(ov), 64'(m_ovf[idx]));
        chk({n, "_drops"}, 64'(dc), 64'(m_drops[idx]));
        chk({n, "_pc"}, 64'(pc), 64'(h.pc));
        chk({n, "_addr"}, 64'(a), 64'(h.addr));
        chk({n, "_data"}, 64'(d), 64'(h.data));
    endtask

    task automatic check_all();
        ent_t h;
        check_dut(0, "stop", s_valid, s_state, s_ovf, s_drop, s_pc, s_addr, s_data);
        check_dut(1, "drop", d_valid, d_state, d_ovf, d_drop, d_pc, d_addr, d_data);
`ifdef TRACE_TIMESTAMP_EN
        h = qhead(0);
        chk("stop_time", 64'(s_time), 64'(h.ts));
        h = qhead(1);
        chk("drop_time", 64'(d_time), 64'(h.ts));
`else
        h = '0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_one(0, 1'b1);
        model_one(1, 1'b0);
        if (!rst || clear) m_time = '0; else m_time = m_time + 32'd1;
        #1;
        check_all();
    endtask

    task automatic wr(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        prog_count     = pc;
        reg_write      = 1'b1;
        write_reg_addr = a;
        write_reg_data = d;
        step();
        reg_write      = 1'b0;
    endtask

    initial begin
        logic [31:0] t0;
        rst = 1'b0; prog_count = '0; reg_write = 1'b0; write_reg_addr = '0;
        write_reg_data = '0; trig_pc = '0; arm = 1'b0; clear = 1'b0; trace_ready = 1'b0;
        m_time = '0;
        t0 = '0;
        step();
        step();
        chk("reset_valid", 64'(s_valid), 64'(0));
        chk("reset_state", 64'(s_state), 64'(0));
        rst = 1'b1;

        // Trigger at 0x10: the pre-trigger write must not be captured.
        trig_pc = 32'h10;
        arm = 1'b1; step(); arm = 1'b0;
        wr(32'h0C, 5'd8, 32'h1);
        wr(32'h10, 5'd9, 32'd5);
        wr(32'h14, 5'd10, 32'd7);
        chk("t2_head_pc", 64'(s_pc), 64'(32'h10));
        chk("t2_head_addr", 64'(s_addr), 64'(9));
        chk("t2_head_data", 64'(s_data), 64'(5));
        trace_ready = 1'b1; step();
        chk("t2_second_pc", 64'(s_pc), 64'(32'h14));
        chk("t2_second_addr", 64'(s_addr), 64'(10));
        chk("t2_second_data", 64'(s_data), 64'(7));
        step();
        chk("t2_drained", 64'(s_valid), 64'(0));
        trace_ready = 1'b0;

        // Reset while running with three entries queued.
        for (int i = 0; i < 3; i++) wr(32'h20 + 32'(4 * i), 5'd1, 32'(i));
        chk("t1_pre_valid", 64'(d_valid), 64'(1));
        chk("t1_pre_state", 64'(d_state), 64'(2));
        rst = 1'b0; step(); rst = 1'b1;
        chk("t1_valid", 64'(s_valid), 64'(0));
        chk("t1_state", 64'(s_state), 64'(0));
        chk("t1_drops", 64'(d_drop), 64'(0));

        // Twenty events with no consumer: stop instance halts, drop instance loses four.
        trig_pc = 32'h100;
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr(32'h100 + 32'(4 * i), 5'(1 + i % 31), 32'(i));
            if (i == 15) chk("t3_done_at_16", 64'(s_state), 64'(3));
        end
        chk("t3_drops", 64'(s_drop), 64'(0));
        chk("t3_state", 64'(s_state), 64'(3));
        chk("t4_overflow", 64'(d_ovf), 64'(1));
        chk("t4_drops", 64'(d_drop), 64'(4));
        trace_ready = 1'b1;
        wr(32'h200, 5'd3, 32'hAA);
        chk("t4_pushpop_drops", 64'(d_drop), 64'(4));
        chk("t4_pushpop_head", 64'(d_pc), 64'(32'h104));
        for (int i = 0; i < 18; i++) step();
        chk("t4_drained", 64'(d_valid), 64'(0));
        trace_ready = 1'b0;

        // Writes to $zero are ignored; clear beats arm.
        clear = 1'b1; step(); clear = 1'b0;
        trig_pc = 32'h300;
        arm = 1'b1; step(); arm = 1'b0;
        wr(32'h300, 5'd5, 32'h1);
        wr(32'h304, 5'd0, 32'hDEAD);
        trace_ready = 1'b1; step(); trace_ready = 1'b0;
        chk("t5_zero_reg", 64'(s_valid), 64'(0));
        wr(32'h308, 5'd6, 32'h2);
        clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
        chk("t5_clear_state", 64'(s_state), 64'(0));
        chk("t5_clear_valid", 64'(s_valid), 64'(0));

`ifdef TRACE_TIMESTAMP_EN
        // Two captures five edges apart carry timestamps five apart.
        trig_pc = 32'h400;
        arm = 1'b1; step(); arm = 1'b0;
        wr(32'h400, 5'd1, 32'h11);
        for (int i = 0; i < 4; i++) step();
        wr(32'h414, 5'd2, 32'h22);
        t0 = s_time;
        trace_ready = 1'b1; step(); trace_ready = 1'b0;
        chk("t6_delta", 64'(s_time - t0), 64'(5));
        clear = 1'b1; step(); clear = 1'b0;
`endif

        // Random traffic over a small PC window so triggers recur.
        trig_pc = 32'h8;
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 199) != 0);
            clear          = ($urandom_range(0, 39) == 0);
            arm            = ($urandom_range(0, 5) == 0);
            prog_count     = 32'($urandom_range(0, 15)) << 2;
            reg_write      = ($urandom_range(0, 3) != 0);
            write_reg_addr = 5'($urandom_range(0, 31));
            write_reg_data = $urandom;
            trace_ready    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) trig_pc = 32'($urandom_range(0, 15)) << 2;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
